wb_arbiter_2to1: RTL
====================

# wb_arbiter_2to1

- Two-master, one-slave pipelined Wishbone (B4) arbiter.
- Sits directly downstream of the core's Wishbone wrapper: its data and instruction master ports feed a single shared slave (unified RAM or peripheral bus).
- Grants whole bus cycles (CYC-to-CYC), alternates round-robin on contention, bounds outstanding requests, and recovers a hung slave with a timeout error.

## Interface

Parameters:
- MaxOutstanding, 8: maximum accepted-but-unacknowledged requests per grant; range 1..15.
- TimeoutCycles, 255: cycles without ACK/ERR while requests are outstanding before timeout; 0 disables.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- m0  wishbone_if.slave  bundle  master 0, connected to the data port.
- m1  wishbone_if.slave  bundle  master 1, connected to the instruction port.
- s  wishbone_if.master  bundle  shared slave.
- All bundles carry:
  - master to slave: cyc, stb, we, sel[3:0], adr[31:0], dat_w[31:0].
  - slave to master: dat_r[31:0], ack, err, stall.

## Operation

State machine (fsm), with last-granted register (last) and outstanding counter (outst):
- IDLE:
  - Only m0.cyc -> GNT0; only m1.cyc -> GNT1.
  - Both -> the master not equal to last.
  - last is updated on every grant.
- GNT0 / GNT1:
  - Granted master drops cyc, other master's cyc high -> grant the other directly (no IDLE bubble).
  - Granted master drops cyc, otherwise -> IDLE.
  - Timeout -> ABORT.
- ABORT: lasts exactly one cycle, then -> IDLE.

Routing while in GNTx:
- s.cyc = mx.cyc. s.stb, we, sel, adr, dat_w come from mx.
- mx.ack = s.ack, mx.err = s.err, mx.dat_r = s.dat_r.
- mx.stall = s.stall | (outst == MaxOutstanding).
- s.stb is gated low when outst == MaxOutstanding.

Ungranted master, and all masters in IDLE or ABORT:
- stall = 1, ack = 0, err = 0; dat_r is don't-care and driven from s.dat_r.
- In IDLE and ABORT: s.cyc = 0, s.stb = 0.

Outstanding counter outst:
- +1 on an accepted request (s.stb & !s.stall).
- -1 on s.ack | s.err.
- Both in the same cycle: unchanged.
- Cleared on a grant change, on IDLE, and on ABORT.
- Stray ACK/ERR with outst == 0 is dropped (not forwarded) and does not underflow.

Timeout timer:
- Counts cycles with outst > 0 and no s.ack/s.err.
- Resets on any ACK/ERR and whenever outst == 0.
- Reaching TimeoutCycles while in GNTx:
  - pulses err to mx for one cycle;
  - moves to ABORT, which forces s.cyc low for one cycle so the slave sees an abort.

## Timing

- Arbitration latency: s.cyc rises one cycle after the first requesting mx.cyc in IDLE.
- Hand-over between masters: zero-cycle gap. Cycle N has m0.cyc low; cycle N+1 drives m1 on s.
- Routing of requests and responses during a grant is combinational.
- Reset values:
  - fsm = IDLE, last = m1 (so m0 wins the first tie), outst = 0, timer = 0.
  - s.cyc/stb/we = 0, s.sel/adr/dat_w = 0.
  - m0/m1: stall = 1, ack = 0, err = 0.
- Reset asserted mid-transfer: all of the above applies immediately (asynchronous); in-flight responses are lost.
- Granted master drops cyc with outst > 0: this is a Wishbone abort. It is propagated the same cycle, and late slave ACKs are dropped.
- TimeoutCycles == 0: the timer never fires and ABORT is unreachable.

## Structure

- Package wb_arb_pkg holds:
  - state enum arb_state_e {IDLE, GNT0, GNT1, ABORT};
  - grant index type;
  - the outstanding-counter width constant (4 bits).
- Sub-module wb_arb_watchdog holds the timeout timer.
  - Inputs: active, ack/err, and clear.
  - Output: single-cycle timeout pulse.
  - Width is derived from TimeoutCycles.

## Test plan

- Single master: m1 issues 4 pipelined reads to 0x0000_0100..0x10C, and the slave acks each after 2 cycles.
  - Required: s.cyc rises 1 cycle after m1.cyc; m1 receives 4 ACKs with the matching dat_r; m0 sees stall = 1 throughout.
- Tie: m0 and m1 assert cyc in the same cycle out of reset.
  - Required: m0 is granted first; when m0 drops cyc, m1 is granted the next cycle with no IDLE bubble.
  - Required: on the next tie, m1 wins.
- Outstanding limit: MaxOutstanding = 2, the slave holds ACK, and m0 pushes 3 writes with sel = 4'b0011.
  - Required: the third is stalled and s.stb stays low.
  - Required: after one ACK, the third is accepted.
- Timeout: TimeoutCycles = 16 and the slave never acks one accepted read.
  - Required: m0.err pulses in cycle 16, then s.cyc = 0 for one cycle (ABORT), then IDLE.
- Abort/stray: m1 drops cyc with 1 outstanding, and the slave acks 2 cycles later while m0 is granted.
  - Required: the stale ACK is not delivered to m0, and outst does not go negative.
- Reset mid-burst: rst_ni pulses low during GNT0 with 3 outstanding.
  - Required: outputs take their reset values immediately; after release, a fresh m1 request is granted normally.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    typedef logic gnt_idx_t;

    localparam int unsigned OutstW = 4;
    typedef logic [OutstW-1:0] outst_t;

    function automatic gnt_idx_t other_master(input gnt_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone B4 bundle; master drives requests, slave drives responses.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/wb_arb_watchdog.sv
// Counts response-less cycles while requests are outstanding and flags a hung slave.
module wb_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic resp_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned TimerW  = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
    localparam bit          Enabled = (TimeoutCycles != 0);
    localparam logic [TimerW-1:0] Limit = TimerW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    logic [TimerW-1:0] timer_r;
    logic [TimerW-1:0] timer_nxt_s;

    // next timer value: restart on any response or idle, saturate at the limit
    always_comb begin
        timer_nxt_s = timer_r;
        if (clear_i || !active_i || resp_i) begin
            timer_nxt_s = '0;
        end else if (timer_r != Limit) begin
            timer_nxt_s = timer_r + 1'b1;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // timer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_nxt_s;
        end
    end

    // fires in the TimeoutCycles-th waiting cycle, same cycle the error is forwarded
    assign timeout_o = Enabled && active_i && !resp_i && (timer_r == Limit);

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave pipelined Wishbone arbiter: whole-cycle grants,
// round-robin on ties, bounded outstanding requests and slave-hang recovery.
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned TimeoutCycles  = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wishbone_if.slave  m0,
    wishbone_if.slave  m1,
    wishbone_if.master s
);

    localparam outst_t MaxOut = outst_t'(MaxOutstanding);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    gnt_idx_t   last_r;
    outst_t     outst_r;
    outst_t     outst_nxt_s;

    logic        granted_s;
    gnt_idx_t    gidx_s;
    logic        full_s;
    logic        live_s;
    logic        accept_s;
    logic        resp_s;
    logic        timeout_s;
    logic        clear_s;

    logic        req_cyc_s;
    logic        req_stb_s;
    logic        req_we_s;
    logic [3:0]  req_sel_s;
    logic [31:0] req_adr_s;
    logic [31:0] req_dat_s;

    logic        s_cyc_s;
    logic        s_stb_s;
    logic        s_we_s;
    logic [3:0]  s_sel_s;
    logic [31:0] s_adr_s;
    logic [31:0] s_dat_s;

    logic        m0_stall_s, m0_ack_s, m0_err_s;
    logic        m1_stall_s, m1_ack_s, m1_err_s;

    assign granted_s = (state_r == GNT0) || (state_r == GNT1);
    assign gidx_s    = (state_r == GNT1);
    assign full_s    = (outst_r == MaxOut);
    // responses with nothing outstanding are stale leftovers of an aborted cycle
    assign live_s    = granted_s && (outst_r != '0);
    assign resp_s    = (s.ack || s.err) && live_s;
    assign accept_s  = s_stb_s && !s.stall;
    assign clear_s   = (state_nxt_s != state_r);

    // request mux from the granted master
    always_comb begin
        req_cyc_s = m0.cyc;
        req_stb_s = m0.stb;
        req_we_s  = m0.we;
        req_sel_s = m0.sel;
        req_adr_s = m0.adr;
        req_dat_s = m0.dat_w;
        if (gidx_s) begin
            req_cyc_s = m1.cyc;
            req_stb_s = m1.stb;
            req_we_s  = m1.we;
            req_sel_s = m1.sel;
            req_adr_s = m1.adr;
            req_dat_s = m1.dat_w;
        end else begin
            req_cyc_s = m0.cyc;
            req_stb_s = m0.stb;
            req_we_s  = m0.we;
            req_sel_s = m0.sel;
            req_adr_s = m0.adr;
            req_dat_s = m0.dat_w;
        end
    end

    // slave-side drive: quiet bus unless a master holds the grant
    always_comb begin
        s_cyc_s = 1'b0;
        s_stb_s = 1'b0;
        s_we_s  = 1'b0;
        s_sel_s = 4'h0;
        s_adr_s = 32'h0;
        s_dat_s = 32'h0;
        if (granted_s) begin
            s_cyc_s = req_cyc_s;
            s_stb_s = req_stb_s && req_cyc_s && !full_s;
            s_we_s  = req_we_s;
            s_sel_s = req_sel_s;
            s_adr_s = req_adr_s;
            s_dat_s = req_dat_s;
        end else begin
            s_cyc_s = 1'b0;
            s_stb_s = 1'b0;
        end
    end

    assign s.cyc   = s_cyc_s;
    assign s.stb   = s_stb_s;
    assign s.we    = s_we_s;
    assign s.sel   = s_sel_s;
    assign s.adr   = s_adr_s;
    assign s.dat_w = s_dat_s;

    // response routing: only the granted master sees the slave
    always_comb begin
        m0_stall_s = 1'b1;
        m0_ack_s   = 1'b0;
        m0_err_s   = 1'b0;
        m1_stall_s = 1'b1;
        m1_ack_s   = 1'b0;
        m1_err_s   = 1'b0;
        if (state_r == GNT0) begin
            m0_stall_s = s.stall || full_s;
            m0_ack_s   = s.ack && live_s;
            m0_err_s   = (s.err && live_s) || timeout_s;
        end else if (state_r == GNT1) begin
            m1_stall_s = s.stall || full_s;
            m1_ack_s   = s.ack && live_s;
            m1_err_s   = (s.err && live_s) || timeout_s;
        end else begin
            m0_stall_s = 1'b1;
            m1_stall_s = 1'b1;
        end
    end

    assign m0.stall = m0_stall_s;
    assign m0.ack   = m0_ack_s;
    assign m0.err   = m0_err_s;
    assign m0.dat_r = s.dat_r;
    assign m1.stall = m1_stall_s;
    assign m1.ack   = m1_ack_s;
    assign m1.err   = m1_err_s;
    assign m1.dat_r = s.dat_r;

    // next-state: whole-cycle grants, direct hand-over when the other master waits
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nxt_s = (other_master(last_r) == 1'b0) ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_nxt_s = GNT0;
                end else if (m1.cyc) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (timeout_s) begin
                    state_nxt_s = ABORT;
                end else if (!m0.cyc) begin
                    state_nxt_s = m1.cyc ? GNT1 : IDLE;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (timeout_s) begin
                    state_nxt_s = ABORT;
                end else if (!m1.cyc) begin
                    state_nxt_s = m0.cyc ? GNT0 : IDLE;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            ABORT:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // outstanding count, restarted whenever the grant changes or lapses
    always_comb begin
        outst_nxt_s = outst_r;
        if (clear_s || !granted_s) begin
            outst_nxt_s = '0;
        end else begin
            case ({accept_s, resp_s})
                2'b10:   outst_nxt_s = outst_r + 1'b1;
                2'b01:   outst_nxt_s = outst_r - 1'b1;
                default: outst_nxt_s = outst_r;
            endcase
        end
    end

    // state, last-granted and outstanding registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            outst_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            outst_r <= outst_nxt_s;
            if (state_nxt_s == GNT0) begin
                last_r <= 1'b0;
            end else if (state_nxt_s == GNT1) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
        end
    end

    wb_arb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .active_i  (live_s),
        .resp_i    (s.ack || s.err),
        .clear_i   (clear_s),
        .timeout_o (timeout_s)
    );

endmodule
